// File: rtl/dff_arb_pkg.sv
// Shared types and helpers for the round-robin shared-register write arbiter.
package dff_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    LOCK  = 2'd2
  } state_t;

  // Requester index width; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dff_rr_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import dff_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned BW_ID = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [BW_ID-1:0] ptr,
  output logic [BW_ID-1:0] winner_c,
  output logic             any_c
);

  localparam int unsigned SW = BW_ID + 1;

  logic [SW-1:0]    sum;
  logic [BW_ID-1:0] idx;

  // Scan ptr, ptr+1, ... with modulo-N_REQ wrap so non-power-of-2 counts work.
  always_comb begin
    winner_c = '0;
    any_c    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(N_REQ)) begin
        sum = sum - SW'(N_REQ);
      end
      idx = sum[BW_ID-1:0];
      if (!any_c && req[idx]) begin
        winner_c = idx;
        any_c    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_rr_arb.sv
// Round-robin write sequencer for one shared register, with bounded lock bursts.
module dff_rr_arb
  import dff_arb_pkg::*;
#(
  parameter  int unsigned N_REQ    = 4,
  parameter  int unsigned BW_DATA  = 32,
  parameter  int unsigned LOCK_MAX = 8,
  localparam int unsigned BW_ID    = id_width(N_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ-1:0]         i_lock,
  input  logic [N_REQ*BW_DATA-1:0] i_data,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [BW_DATA-1:0]       o_q,
  output logic [BW_ID-1:0]         o_q_id,
  output logic                     o_q_vld
);

  localparam int unsigned BW_LCNT = $clog2(LOCK_MAX + 1);

  state_t              state;
  logic [BW_ID-1:0]    owner;
  logic [BW_ID-1:0]    rr_ptr;
  logic [BW_LCNT-1:0]  lock_cnt;

  logic [BW_ID-1:0]    pick_id_c;
  logic                pick_any_c;
  logic                own_req_c;
  logic                own_lock_c;
  logic [BW_DATA-1:0]  own_data_c;
  logic [BW_ID-1:0]    next_ptr_c;
  logic                lock_done_c;

  rr_pick #(
    .N_REQ (N_REQ),
    .BW_ID (BW_ID)
  ) u_pick (
    .req      (i_req),
    .ptr      (rr_ptr),
    .winner_c (pick_id_c),
    .any_c    (pick_any_c)
  );

  // Only the current owner's request, lock hint and data matter once granted.
  assign own_req_c   = i_req[owner];
  assign own_lock_c  = i_lock[owner];
  assign own_data_c  = i_data[owner*BW_DATA +: BW_DATA];
  assign next_ptr_c  = (owner == BW_ID'(N_REQ - 1)) ? '0 : owner + 1'b1;
  assign lock_done_c = (lock_cnt == BW_LCNT'(LOCK_MAX));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      lock_cnt <= '0;
      o_gnt    <= '0;
      o_q      <= '0;
      o_q_id   <= '0;
      o_q_vld  <= 1'b0;
    end else begin
      o_q_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any_c) begin
            owner <= pick_id_c;
            o_gnt <= N_REQ'(1) << pick_id_c;
            state <= GRANT;
          end else begin
            o_gnt <= '0;
          end
        end

        GRANT: begin
          if (own_req_c) begin
            o_q     <= own_data_c;
            o_q_id  <= owner;
            o_q_vld <= 1'b1;
          end
          rr_ptr <= next_ptr_c;
          if (own_req_c && own_lock_c) begin
            lock_cnt <= BW_LCNT'(1);
            state    <= LOCK;
          end else begin
            o_gnt <= '0;
            state <= IDLE;
          end
        end

        LOCK: begin
          if (own_req_c) begin
            o_q      <= own_data_c;
            o_q_id   <= owner;
            o_q_vld  <= 1'b1;
            lock_cnt <= lock_cnt + 1'b1;
          end
          // Release on withdrawal, dropped lock hint, or burst limit reached.
          if (!own_req_c || !own_lock_c || lock_done_c) begin
            lock_cnt <= '0;
            o_gnt    <= '0;
            state    <= IDLE;
          end
        end

        default: begin
          o_gnt <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_rr_arb.sv
// Bench for dff_rr_arb: directed vector table, lock/reset sequences, random vs model.
module tb_dff_rr_arb;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int LM = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] data;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic [1:0]     q_id;
  logic           q_vld;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: tenure-based view of the arbiter.
  bit           m_busy;
  int           m_ptr, m_owner, m_burst, m_id;
  logic [N-1:0] m_gnt;
  logic [W-1:0] m_q;
  bit           m_vld;

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [W-1:0] d2;
    logic [N-1:0] gnt;
    logic         vld;
    logic [W-1:0] q;
    logic [1:0]   id;
  } vec_t;

  vec_t vt[24];

  always #5 clk = ~clk;

  dff_rr_arb #(
    .N_REQ    (N),
    .BW_DATA  (W),
    .LOCK_MAX (LM)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (req),
    .i_lock  (lock),
    .i_data  (data),
    .o_gnt   (gnt),
    .o_q     (q),
    .o_q_id  (q_id),
    .o_q_vld (q_vld)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic set_data(input int k, input logic [W-1:0] v);
    data[k*W +: W] = v;
  endtask

  task automatic model_step();
    logic r;
    int   cand;
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_owner = 0; m_burst = 0;
      m_gnt = '0; m_q = '0; m_id = 0; m_vld = 0;
    end else if (!m_busy) begin
      m_vld = 0;
      m_gnt = '0;
      for (int k = 0; k < N; k++) begin
        cand = (m_ptr + k) % N;
        if (!m_busy && req[cand]) begin
          m_busy  = 1;
          m_owner = cand;
          m_burst = 0;
          m_gnt   = N'(1) << cand;
        end
      end
    end else begin
      r     = req[m_owner];
      m_vld = r;
      if (r) begin
        m_q = data[m_owner*W +: W];
        m_id = m_owner;
        m_burst++;
      end
      m_ptr = (m_owner + 1) % N;
      // A tenure allows one granted write plus at most LM locked writes.
      if (!(r && lock[m_owner] && m_burst <= LM)) begin
        m_busy = 0;
        m_gnt  = '0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [N-1:0] e_gnt, input logic e_vld,
                         input logic [W-1:0] e_q, input logic [1:0] e_id);
    chk({tag, ".gnt"}, W'(gnt), W'(e_gnt));
    chk({tag, ".vld"}, W'(q_vld), W'(e_vld));
    chk({tag, ".q"}, q, e_q);
    chk({tag, ".id"}, W'(q_id), W'(e_id));
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    lock = '0;
    for (int k = 0; k < N; k++) set_data(k, W'(32'h10 + k));

    //            rst   req      d2            gnt      vld   q             id
    vt[0]  = '{1'b1, 4'b0000, 32'hDEADBEEF, 4'b0000, 1'b0, 32'h0,        2'd0};
    vt[1]  = '{1'b0, 4'b0100, 32'hDEADBEEF, 4'b0100, 1'b0, 32'h0,        2'd0};
    vt[2]  = '{1'b0, 4'b0100, 32'hDEADBEEF, 4'b0000, 1'b1, 32'hDEADBEEF, 2'd2};
    vt[3]  = '{1'b0, 4'b0000, 32'hDEADBEEF, 4'b0000, 1'b0, 32'hDEADBEEF, 2'd2};
    vt[4]  = '{1'b0, 4'b0011, 32'h12,       4'b0001, 1'b0, 32'hDEADBEEF, 2'd2};
    vt[5]  = '{1'b0, 4'b0011, 32'h12,       4'b0000, 1'b1, 32'h10,       2'd0};
    vt[6]  = '{1'b0, 4'b0011, 32'h12,       4'b0010, 1'b0, 32'h10,       2'd0};
    vt[7]  = '{1'b0, 4'b0011, 32'h12,       4'b0000, 1'b1, 32'h11,       2'd1};
    vt[8]  = '{1'b1, 4'b1111, 32'h12,       4'b0000, 1'b0, 32'h0,        2'd0};
    vt[9]  = '{1'b0, 4'b1111, 32'h12,       4'b0001, 1'b0, 32'h0,        2'd0};
    vt[10] = '{1'b0, 4'b1111, 32'h12,       4'b0000, 1'b1, 32'h10,       2'd0};
    vt[11] = '{1'b0, 4'b1111, 32'h12,       4'b0010, 1'b0, 32'h10,       2'd0};
    vt[12] = '{1'b0, 4'b1111, 32'h12,       4'b0000, 1'b1, 32'h11,       2'd1};
    vt[13] = '{1'b0, 4'b1111, 32'h12,       4'b0100, 1'b0, 32'h11,       2'd1};
    vt[14] = '{1'b0, 4'b1111, 32'h12,       4'b0000, 1'b1, 32'h12,       2'd2};
    vt[15] = '{1'b0, 4'b1111, 32'h12,       4'b1000, 1'b0, 32'h12,       2'd2};
    vt[16] = '{1'b0, 4'b1111, 32'h12,       4'b0000, 1'b1, 32'h13,       2'd3};
    vt[17] = '{1'b0, 4'b1111, 32'h12,       4'b0001, 1'b0, 32'h13,       2'd3};
    vt[18] = '{1'b0, 4'b1111, 32'h12,       4'b0000, 1'b1, 32'h10,       2'd0};
    vt[19] = '{1'b1, 4'b0000, 32'h12,       4'b0000, 1'b0, 32'h0,        2'd0};
    vt[20] = '{1'b0, 4'b1000, 32'h12,       4'b1000, 1'b0, 32'h0,        2'd0};
    vt[21] = '{1'b0, 4'b0000, 32'h12,       4'b0000, 1'b0, 32'h0,        2'd0};
    vt[22] = '{1'b0, 4'b0011, 32'h12,       4'b0001, 1'b0, 32'h0,        2'd0};
    vt[23] = '{1'b0, 4'b0011, 32'h12,       4'b0000, 1'b1, 32'h10,       2'd0};

    for (int i = 0; i < 24; i++) begin
      rst = vt[i].rst;
      req = vt[i].req;
      set_data(2, vt[i].d2);
      tick();
      chk_out($sformatf("vec%0d", i), vt[i].gnt, vt[i].vld, vt[i].q, vt[i].id);
    end

    // Locked burst by requester 1 with requester 0 pending; rr_ptr is 1 here.
    req  = 4'b0011;
    lock = 4'b0010;
    set_data(1, 32'h0);
    tick();
    chk("lock.gnt0", W'(gnt), W'(4'b0010));
    for (int w = 0; w <= LM; w++) begin
      set_data(1, W'(w));
      tick();
      chk_out($sformatf("lock.w%0d", w), (w < LM) ? 4'b0010 : 4'b0000, 1'b1, W'(w), 2'd1);
    end
    tick();
    chk_out("lock.next", 4'b0001, 1'b0, W'(LM), 2'd1);
    lock = '0;
    tick();
    chk_out("lock.next_wr", 4'b0000, 1'b1, 32'h10, 2'd0);

    // Reset while in LOCK.
    req  = 4'b0010;
    lock = 4'b0010;
    set_data(1, 32'h55);
    tick();
    chk("rstlk.gnt", W'(gnt), W'(4'b0010));
    tick();
    chk_out("rstlk.w0", 4'b0010, 1'b1, 32'h55, 2'd1);
    tick();
    chk_out("rstlk.w1", 4'b0010, 1'b1, 32'h55, 2'd1);
    rst = 1'b1;
    req = 4'b0011;
    tick();
    chk_out("rstlk.rst", 4'b0000, 1'b0, 32'h0, 2'd0);
    rst  = 1'b0;
    lock = '0;
    tick();
    chk("rstlk.regnt", W'(gnt), W'(4'b0001));
    tick();
    chk_out("rstlk.rewr", 4'b0000, 1'b1, 32'h10, 2'd0);

    // Random traffic against the model, starting from a clean reset.
    rst = 1'b1;
    tick();
    for (int c = 0; c < 600; c++) begin
      rst  = ($urandom_range(0, 79) == 0);
      req  = N'($urandom);
      lock = ($urandom_range(0, 3) != 0) ? N'($urandom | 32'h0000_000F & $urandom) : '0;
      for (int k = 0; k < N; k++) set_data(k, W'($urandom));
      tick();
      chk_out($sformatf("rnd%0d", c), m_gnt, m_vld, m_q, 2'(m_id));
      chk($sformatf("rnd%0d.onehot", c), W'($countones(gnt) <= 1), 32'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
